i2s_tx_dsp_channel: RTL

- Slave-mode DSP/TDM transmitter for the uDMA I2S peripheral; the mirror of the DSP receive channel.
- Pulls 32-bit words from the TX FIFO, waits for the external frame sync on i2s_ws_i, skips a programmable bit offset, then serialises ch0 (and optionally ch1) back-to-back at sck_i rate.
- Clock polarity selection (inversion/mux) is done outside this block. Here everything is on posedge sck_i.

---
 rtl/i2s_pkg.sv | 33 +++
 rtl/i2s_tx_dsp_shifter.sv | 57 +++++
 rtl/i2s_tx_dsp_channel.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DSP/TDM transmit channel.
//   tx_dsp_state_t : transmit FSM states
//   BITS_*         : supported word sizes, expressed as bits-per-word minus 1
//   snap_num_bits  : maps a bit-count setting onto a supported word size
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFSET,
    RUN,
    DONE
  } tx_dsp_state_t;

  localparam logic [4:0] BITS_8  = 5'd7;
  localparam logic [4:0] BITS_16 = 5'd15;
  localparam logic [4:0] BITS_24 = 5'd23;
  localparam logic [4:0] BITS_32 = 5'd31;

  // Only 8/16/24/32-bit words are supported; any other setting is rounded
  // up to the next supported size so the bit counter always terminates on
  // a byte boundary.
  function automatic logic [4:0] snap_num_bits(input logic [4:0] num_bits);
    logic [4:0] snapped;
    case (num_bits[4:3])
      2'd0:    snapped = BITS_8;
      2'd1:    snapped = BITS_16;
      2'd2:    snapped = BITS_24;
      default: snapped = BITS_32;
    endcase
    return snapped;
  endfunction

endpackage

// File: rtl/i2s_tx_dsp_shifter.sv
// One serialising shift register for a single TX channel.
// The first bit of a word is registered onto sdo on the load edge itself;
// every shift edge then presents the next bit.
//   clk, rst_n : bit clock, asynchronous active-low reset
//   clr        : synchronous clear of register and output
//   load       : capture load_data and drive its first bit
//   shift      : drive the next bit of the held word
//   lsb_first  : 1 = bit 0 upward, 0 = bit last_bit downward
//   last_bit   : index of the top bit of the word
//   load_data  : word to serialise (LSB-aligned)
//   sdo        : registered serial output
module i2s_tx_dsp_shifter
  import i2s_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic        shift,
  input  logic        lsb_first,
  input  logic [4:0]  last_bit,
  input  logic [31:0] load_data,
  output logic        sdo
);

  logic [31:0] shreg;

  // The register holds the bits still to be sent. MSB-first keeps the next
  // bit at index last_bit by shifting left, so bits above last_bit never
  // reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      sdo   <= 1'b0;
    end else if (clr) begin
      shreg <= '0;
      sdo   <= 1'b0;
    end else if (load) begin
      if (lsb_first) begin
        sdo   <= load_data[0];
        shreg <= load_data >> 1;
      end else begin
        sdo   <= load_data[last_bit];
        shreg <= load_data << 1;
      end
    end else if (shift) begin
      if (lsb_first) begin
        sdo   <= shreg[0];
        shreg <= shreg >> 1;
      end else begin
        sdo   <= shreg[last_bit];
        shreg <= shreg << 1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_dsp_channel.sv
// Slave-mode DSP/TDM transmit channel. Prefetches words from the TX FIFO
// into one buffer per channel, waits for a frame sync on i2s_ws_i, skips a
// programmable number of sck cycles and serialises ch0 (and ch1 in
// two-channel mode) on posedge sck_i.
//   sck_i, rstn_i          : bit clock, asynchronous active-low reset
//   i2s_ws_i               : external frame sync
//   i2s_ch0_o, i2s_ch1_o   : serial data outputs
//   fifo_data_*            : TX FIFO valid/ready interface
//   fifo_err_o             : one-cycle pulse when a word had to be zero-filled
//   cfg_*                  : enable, channel mode, word size, word count,
//                            bit order, continuous mode, frame-sync offset
module i2s_tx_dsp_channel
  import i2s_pkg::*;
(
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        i2s_ws_i,
  output logic        i2s_ch0_o,
  output logic        i2s_ch1_o,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_data_valid_i,
  output logic        fifo_data_ready_o,
  output logic        fifo_err_o,
  input  logic        cfg_en_i,
  input  logic        cfg_2ch_i,
  input  logic [4:0]  cfg_num_bits_i,
  input  logic [3:0]  cfg_num_word_i,
  input  logic        cfg_lsb_first_i,
  input  logic        cfg_tx_continuous_i,
  input  logic [8:0]  cfg_slave_dsp_offset_i
);

  tx_dsp_state_t state, state_next;

  logic [31:0] buf0, buf1;
  logic        buf0_v, buf1_v;
  logic [4:0]  count_bit;
  logic [4:0]  count_word;   // one bit wider so num_word=15 (16 words) fits
  logic [8:0]  count_offset;

  logic [4:0]  last_bit;
  logic [4:0]  word_total;
  logic        need_more;
  logic        underrun;
  logic        accept;
  logic        load, shift, flush, going_done, out_clr;
  logic [31:0] load_data0, load_data1;

  assign last_bit   = snap_num_bits(cfg_num_bits_i);
  assign word_total = {1'b0, cfg_num_word_i} + 5'd1;

  // In counted mode stop prefetching once every word of the burst has been
  // loaded, so surplus FIFO words stay in the FIFO.
  assign need_more = cfg_tx_continuous_i | (count_word <= {1'b0, cfg_num_word_i});

  assign fifo_data_ready_o = rstn_i & cfg_en_i & (state != DONE) & need_more &
                             (~buf0_v | (cfg_2ch_i & ~buf1_v));
  assign accept   = fifo_data_valid_i & fifo_data_ready_o;
  assign underrun = ~buf0_v | (cfg_2ch_i & ~buf1_v);

  // Empty buffers load as zero; ch1 is forced to zero in one-channel mode.
  assign load_data0 = buf0_v ? buf0 : '0;
  assign load_data1 = (cfg_2ch_i & buf1_v) ? buf1 : '0;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    flush      = 1'b0;
    going_done = 1'b0;
    if (!cfg_en_i) begin
      state_next = IDLE;
      flush      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i2s_ws_i) begin
            if (cfg_slave_dsp_offset_i == 9'd0) begin
              state_next = RUN;
              load       = 1'b1;
            end else begin
              state_next = OFFSET;
            end
          end
        end
        OFFSET: begin
          if (count_offset == cfg_slave_dsp_offset_i) begin
            state_next = RUN;
            load       = 1'b1;
          end
        end
        RUN: begin
          if (count_bit == last_bit) begin
            if (!cfg_tx_continuous_i && (count_word == word_total)) begin
              state_next = DONE;
              going_done = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            shift = 1'b1;
          end
        end
        DONE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  assign out_clr = flush | going_done;

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      count_bit    <= '0;
      count_word   <= '0;
      count_offset <= '0;
      fifo_err_o   <= 1'b0;
    end else begin
      state      <= state_next;
      fifo_err_o <= load & underrun;

      // The edge leaving IDLE counts as the first offset cycle, so offset N
      // puts the first bit N cycles later than offset 0.
      if (state_next == OFFSET) count_offset <= count_offset + 9'd1;
      else                      count_offset <= '0;

      if (load || out_clr) count_bit <= '0;
      else if (shift)      count_bit <= count_bit + 5'd1;

      if (flush)                             count_word <= '0;
      else if (load && !cfg_tx_continuous_i) count_word <= count_word + 5'd1;
    end
  end

  // On a load edge both buffers are released, so a word arriving on that
  // same edge is the start of the next pair and goes to buf0.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf0   <= '0;
      buf1   <= '0;
      buf0_v <= 1'b0;
      buf1_v <= 1'b0;
    end else if (flush) begin
      buf0_v <= 1'b0;
      buf1_v <= 1'b0;
    end else begin
      if (load) begin
        buf0_v <= 1'b0;
        buf1_v <= 1'b0;
      end
      if (accept) begin
        if (!buf0_v || load) begin
          buf0   <= fifo_data_i;
          buf0_v <= 1'b1;
        end else begin
          buf1   <= fifo_data_i;
          buf1_v <= 1'b1;
        end
      end
    end
  end

  i2s_tx_dsp_shifter u_shift_ch0 (
    .clk       (sck_i),
    .rst_n     (rstn_i),
    .clr       (out_clr),
    .load      (load),
    .shift     (shift),
    .lsb_first (cfg_lsb_first_i),
    .last_bit  (last_bit),
    .load_data (load_data0),
    .sdo       (i2s_ch0_o)
  );

  i2s_tx_dsp_shifter u_shift_ch1 (
    .clk       (sck_i),
    .rst_n     (rstn_i),
    .clr       (out_clr),
    .load      (load),
    .shift     (shift),
    .lsb_first (cfg_lsb_first_i),
    .last_bit  (last_bit),
    .load_data (load_data1),
    .sdo       (i2s_ch1_o)
  );

endmodule
